// File: rtl/cache_cmd_sequencer_if.sv
// Command, array, lookup, MESI and print-walk signals of the L1 cache command sequencer.
// master is the sequencer side; slave is the surrounding cache model.
interface cache_cmd_sequencer_if #(
  parameter int unsigned IDX_W = 14
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_n;
  logic [31:0]      cmd_addr;
  logic             arr_rd_en;
  logic             arr_wr_en;
  logic [IDX_W-1:0] arr_set;
  logic             arr_sel_i;
  logic             arr_clr;
  logic             lk_valid;
  logic [3:0]       lk_n;
  logic [31:0]      lk_addr;
  logic             lk_hit;
  logic             mesi_req;
  logic             mesi_done;
  logic             dump_valid;
  logic             dump_ready;
  logic             busy;
  logic             err_cmd;
  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;
  logic [31:0]      read_cnt;
  logic [31:0]      write_cnt;

  modport master (
    input  cmd_valid, cmd_n, cmd_addr, lk_hit, mesi_done, dump_ready,
    output cmd_ready, arr_rd_en, arr_wr_en, arr_set, arr_sel_i, arr_clr,
           lk_valid, lk_n, lk_addr, mesi_req, dump_valid, busy, err_cmd,
           hit_cnt, miss_cnt, read_cnt, write_cnt
  );

  modport slave (
    output cmd_valid, cmd_n, cmd_addr, lk_hit, mesi_done, dump_ready,
    input  cmd_ready, arr_rd_en, arr_wr_en, arr_set, arr_sel_i, arr_clr,
           lk_valid, lk_n, lk_addr, mesi_req, dump_valid, busy, err_cmd,
           hit_cnt, miss_cnt, read_cnt, write_cnt
  );
endinterface

// File: rtl/cache_cmd_sequencer.sv
// Runs one trace command at a time: set read, lookup, MESI wait and write-back for
// accesses, plus whole-cache clear and print walks, with hit/miss/read/write statistics.
module cache_cmd_sequencer #(
  parameter int unsigned SETS  = 16384,
  parameter int unsigned IDX_W = 14,
  parameter int unsigned OFF_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_cmd_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, READ, LOOKUP, WAIT_MESI, WRITE, CLEAR, DUMP_RD, DUMP_OUT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  state_t           state;
  logic [IDX_W-1:0] walk_k;
  logic [IDX_W-1:0] cmd_idx_c;
  logic             accept_c;

  assign cmd_idx_c = bus.cmd_addr[OFF_W+IDX_W-1:OFF_W];
  assign accept_c  = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      walk_k         <= '0;
      bus.cmd_ready  <= 1'b0;
      bus.arr_rd_en  <= 1'b0;
      bus.arr_wr_en  <= 1'b0;
      bus.arr_set    <= '0;
      bus.arr_sel_i  <= 1'b0;
      bus.arr_clr    <= 1'b0;
      bus.lk_valid   <= 1'b0;
      bus.lk_n       <= 4'd0;
      bus.lk_addr    <= 32'd0;
      bus.mesi_req   <= 1'b0;
      bus.dump_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.err_cmd    <= 1'b0;
      bus.hit_cnt    <= 32'd0;
      bus.miss_cnt   <= 32'd0;
      bus.read_cnt   <= 32'd0;
      bus.write_cnt  <= 32'd0;
    end else begin
      // single-cycle strobes default low every cycle
      bus.arr_rd_en <= 1'b0;
      bus.arr_wr_en <= 1'b0;
      bus.arr_clr   <= 1'b0;
      bus.mesi_req  <= 1'b0;
      bus.err_cmd   <= 1'b0;

      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (accept_c) begin
            bus.lk_n    <= bus.cmd_n;
            bus.lk_addr <= bus.cmd_addr;
            case (bus.cmd_n)
              4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                state         <= READ;
                bus.cmd_ready <= 1'b0;
                bus.busy      <= 1'b1;
                bus.arr_rd_en <= 1'b1;
                bus.arr_set   <= cmd_idx_c;
                bus.arr_sel_i <= (bus.cmd_n == 4'd2);
              end
              4'd8: begin
                state         <= CLEAR;
                bus.cmd_ready <= 1'b0;
                bus.busy      <= 1'b1;
                bus.arr_wr_en <= 1'b1;
                bus.arr_clr   <= 1'b1;
                bus.arr_set   <= '0;
                bus.arr_sel_i <= 1'b0;
                walk_k        <= '0;
                bus.hit_cnt   <= 32'd0;
                bus.miss_cnt  <= 32'd0;
                bus.read_cnt  <= 32'd0;
                bus.write_cnt <= 32'd0;
              end
              4'd9: begin
                state         <= DUMP_RD;
                bus.cmd_ready <= 1'b0;
                bus.busy      <= 1'b1;
                bus.arr_rd_en <= 1'b1;
                bus.arr_set   <= '0;
                bus.arr_sel_i <= 1'b0;
                walk_k        <= '0;
              end
              default: bus.err_cmd <= 1'b1;
            endcase
          end
        end

        READ: begin
          state        <= LOOKUP;
          bus.lk_valid <= 1'b1;
          bus.mesi_req <= 1'b1;
        end

        LOOKUP: begin
          // invalidate/snoop (3, 4) leave the statistics alone
          if (bus.lk_n == 4'd0 || bus.lk_n == 4'd2) bus.read_cnt <= bus.read_cnt + 32'd1;
          if (bus.lk_n == 4'd1) bus.write_cnt <= bus.write_cnt + 32'd1;
          if (bus.lk_n <= 4'd2) begin
            if (bus.lk_hit) bus.hit_cnt  <= bus.hit_cnt + 32'd1;
            else            bus.miss_cnt <= bus.miss_cnt + 32'd1;
          end
          state <= WAIT_MESI;
        end

        WAIT_MESI: begin
          if (bus.mesi_done) begin
            state         <= WRITE;
            bus.lk_valid  <= 1'b0;
            bus.arr_wr_en <= 1'b1;
          end
        end

        WRITE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end

        CLEAR: begin
          if (walk_k == LAST_SET) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end else begin
            walk_k        <= walk_k + IDX_W'(1);
            bus.arr_set   <= walk_k + IDX_W'(1);
            bus.arr_wr_en <= 1'b1;
            bus.arr_clr   <= 1'b1;
          end
        end

        DUMP_RD: begin
          state          <= DUMP_OUT;
          bus.dump_valid <= 1'b1;
        end

        DUMP_OUT: begin
          if (bus.dump_ready) begin
            bus.dump_valid <= 1'b0;
            if (walk_k == LAST_SET) begin
              state         <= IDLE;
              bus.busy      <= 1'b0;
              bus.cmd_ready <= 1'b1;
            end else begin
              state         <= DUMP_RD;
              walk_k        <= walk_k + IDX_W'(1);
              bus.arr_set   <= walk_k + IDX_W'(1);
              bus.arr_rd_en <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// Scoreboard bench for cache_cmd_sequencer: directed test-plan cases plus random commands,
// expected strobes queued at issue time and checked by an independent monitor.
module tb_cache_cmd_sequencer;
  localparam int unsigned SETS  = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned OFF_W = 6;

  localparam logic [2:0] EV_RD = 3'd0, EV_LK = 3'd1, EV_WR = 3'd2, EV_CLR = 3'd3,
                         EV_DRD = 3'd4, EV_DUMP = 3'd5, EV_ERR = 3'd6;

  typedef struct packed {
    logic [2:0]       kind;
    logic [IDX_W-1:0] set;
    logic             sel;
    logic [3:0]       n;
    logic [31:0]      addr;
  } ev_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] lat;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_cmd_sequencer_if #(.IDX_W(IDX_W)) bus ();
  cache_cmd_sequencer #(.SETS(SETS), .IDX_W(IDX_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int    compared = 0;
  int    mismatched = 0;
  ev_t   exp_q[$];
  resp_t resp_q[$];
  int    stall_total = 0;
  time   acc_time = 0;
  time   prev_acc = 0;
  logic [31:0] m_hit = 0, m_miss = 0, m_rd = 0, m_wr = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [IDX_W-1:0] set_of(input logic [31:0] a);
    return IDX_W'((a >> OFF_W) % SETS);
  endfunction

  function automatic ev_t mk(input logic [2:0] k, input logic [IDX_W-1:0] s, input logic sel,
                             input logic [3:0] n, input logic [31:0] a);
    ev_t e;
    e.kind = k; e.set = s; e.sel = sel; e.n = n; e.addr = a;
    return e;
  endfunction

  // Reference model: expected strobes and statistics derived from the command alone.
  task automatic issue(input logic [3:0] n, input logic [31:0] addr, input logic hit, input int lat);
    logic [IDX_W-1:0] s;
    resp_t r;
    int t;
    s = set_of(addr);
    if (n <= 4'd4) begin
      exp_q.push_back(mk(EV_RD, s, n == 4'd2, 4'd0, 32'd0));
      exp_q.push_back(mk(EV_LK, s, n == 4'd2, n, addr));
      exp_q.push_back(mk(EV_WR, s, n == 4'd2, 4'd0, 32'd0));
      r.hit = hit; r.lat = 8'(lat);
      resp_q.push_back(r);
      if (n == 4'd0 || n == 4'd2) m_rd = m_rd + 1;
      if (n == 4'd1) m_wr = m_wr + 1;
      if (n <= 4'd2) begin
        if (hit) m_hit = m_hit + 1; else m_miss = m_miss + 1;
      end
    end else if (n == 4'd8) begin
      for (int k = 0; k < int'(SETS); k++) exp_q.push_back(mk(EV_CLR, IDX_W'(k), 1'b0, 4'd0, 32'd0));
      m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
    end else if (n == 4'd9) begin
      for (int k = 0; k < int'(SETS); k++) begin
        exp_q.push_back(mk(EV_DRD, IDX_W'(k), 1'b0, 4'd0, 32'd0));
        exp_q.push_back(mk(EV_DUMP, IDX_W'(k), 1'b0, 4'd0, 32'd0));
      end
      stall_total = 0;
    end else begin
      exp_q.push_back(mk(EV_ERR, '0, 1'b0, 4'd0, 32'd0));
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_n     = n;
    bus.cmd_addr  = addr;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("accept_timeout", 64'(t), 64'(0));
    @(posedge clk);
    prev_acc = acc_time;
    acc_time = $time;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_counters();
    check("hit_cnt", 64'(bus.hit_cnt), 64'(m_hit));
    check("miss_cnt", 64'(bus.miss_cnt), 64'(m_miss));
    check("read_cnt", 64'(bus.read_cnt), 64'(m_rd));
    check("write_cnt", 64'(bus.write_cnt), 64'(m_wr));
  endtask

  function automatic logic any_output();
    return |{bus.cmd_ready, bus.arr_rd_en, bus.arr_wr_en, bus.arr_set, bus.arr_sel_i, bus.arr_clr,
             bus.lk_valid, bus.lk_n, bus.lk_addr, bus.mesi_req, bus.dump_valid, bus.busy,
             bus.err_cmd, bus.hit_cnt, bus.miss_cnt, bus.read_cnt, bus.write_cnt};
  endfunction

  // MESI/lookup responder: hit result and done pulse after the programmed extra latency.
  initial begin
    resp_t r;
    bus.lk_hit = 1'b0;
    bus.mesi_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.mesi_req === 1'b1 && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        bus.lk_hit = r.hit;
        bus.mesi_done = 1'($urandom % 2);
        for (int i = 0; i < int'(r.lat); i++) begin
          @(negedge clk);
          bus.mesi_done = 1'b0;
        end
        @(negedge clk);
        bus.mesi_done = 1'b1;
        @(negedge clk);
        bus.mesi_done = 1'b0;
        bus.lk_hit = 1'($urandom % 2);
      end
    end
  end

  // Printer: random back-pressure on each dumped set, noise on dump_ready otherwise.
  initial begin
    int   stall_left;
    logic dv_prev;
    stall_left = 0;
    dv_prev = 1'b0;
    bus.dump_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dump_valid === 1'b1) begin
        if (!dv_prev) begin
          stall_left = int'($urandom_range(0, 2));
          stall_total += stall_left;
        end
        if (stall_left > 0) begin
          bus.dump_ready = 1'b0;
          stall_left--;
        end else begin
          bus.dump_ready = 1'b1;
        end
      end else begin
        bus.dump_ready = 1'($urandom % 2);
      end
      dv_prev = bus.dump_valid;
    end
  end

  function automatic void expect_ev(input logic [2:0] kind, input string name, output ev_t e, output bit ok);
    ok = 1'b0;
    e = '0;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: strobe seen with no expected event (t=%0t)", name, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind) begin
        mismatched++;
        $display("FAIL %s: got event kind %0d, expected kind %0d (t=%0t)", name, kind, e.kind, $time);
      end else ok = 1'b1;
    end
  endfunction

  // Monitor: every strobe the DUT presents must match the head of the scoreboard.
  initial begin
    ev_t  e;
    bit   ok;
    logic mon_dv;
    mon_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (bus.arr_rd_en === 1'b1) begin
          if (exp_q.size() > 0 && exp_q[0].kind == EV_DRD) begin
            expect_ev(EV_DRD, "dump_read", e, ok);
            if (ok) check("dump_read_set", 64'(bus.arr_set), 64'(e.set));
          end else begin
            expect_ev(EV_RD, "array_read", e, ok);
            if (ok) begin
              check("read_set", 64'(bus.arr_set), 64'(e.set));
              check("read_sel_i", 64'(bus.arr_sel_i), 64'(e.sel));
            end
          end
        end
        if (bus.mesi_req === 1'b1) begin
          expect_ev(EV_LK, "lookup", e, ok);
          if (ok) begin
            check("lk_valid", 64'(bus.lk_valid), 64'(1));
            check("lk_n", 64'(bus.lk_n), 64'(e.n));
            check("lk_addr", 64'(bus.lk_addr), 64'(e.addr));
          end
        end
        if (bus.arr_wr_en === 1'b1 && bus.arr_clr !== 1'b1) begin
          expect_ev(EV_WR, "write_back", e, ok);
          if (ok) begin
            check("write_set", 64'(bus.arr_set), 64'(e.set));
            check("write_sel_i", 64'(bus.arr_sel_i), 64'(e.sel));
          end
        end
        if (bus.arr_wr_en === 1'b1 && bus.arr_clr === 1'b1) begin
          expect_ev(EV_CLR, "clear_write", e, ok);
          if (ok) check("clear_set", 64'(bus.arr_set), 64'(e.set));
        end
        if (bus.dump_valid === 1'b1 && mon_dv !== 1'b1) begin
          expect_ev(EV_DUMP, "dump_out", e, ok);
          if (ok) check("dump_set", 64'(bus.arr_set), 64'(e.set));
        end
        if (bus.err_cmd === 1'b1) expect_ev(EV_ERR, "err_cmd", e, ok);
        mon_dv = bus.dump_valid;
      end else begin
        mon_dv = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [3:0] n;
    int r, lat;
    bus.cmd_valid = 1'b0;
    bus.cmd_n = 4'd0;
    bus.cmd_addr = 32'd0;

    // reset state
    @(negedge clk);
    check("reset_outputs_zero", 64'(any_output()), 64'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'(1));

    // read miss, done in first WAIT_MESI cycle
    issue(4'd0, 32'h0000_1040, 1'b0, 0);
    wait_idle(cnt);
    check("rd_busy_cycles", 64'(cnt), 64'(4));
    check_counters();

    // ifetch hit at top of address space, two extra MESI cycles
    issue(4'd2, 32'hFFFF_FFC0, 1'b1, 2);
    wait_idle(cnt);
    check("ifetch_busy_cycles", 64'(cnt), 64'(6));
    check_counters();

    // write then invalidate held on cmd_valid while busy
    issue(4'd1, 32'h1234_5678, 1'b1, 0);
    issue(4'd3, 32'h0BAD_F00D, 1'b0, 0);
    check("back_to_back_accept_gap", 64'((acc_time - prev_acc) / 10), 64'(5));
    wait_idle(cnt);
    check("inval_busy_cycles", 64'(cnt), 64'(4));
    check_counters();

    // clear walk with nonzero counters
    issue(4'd8, 32'd0, 1'b0, 0);
    wait_idle(cnt);
    check("clear_busy_cycles", 64'(cnt), 64'(SETS));
    check_counters();

    // print walk with random back-pressure
    issue(4'd9, 32'd0, 1'b0, 0);
    wait_idle(cnt);
    check("print_busy_cycles", 64'(cnt), 64'(2 * SETS + stall_total));

    // random command mix
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom % 16);
      if (r < 10)       n = 4'(r % 5);
      else if (r == 10) n = 4'd8;
      else if (r == 11) n = 4'd9;
      else              n = 4'(r);
      lat = int'($urandom_range(0, 3));
      issue(n, $urandom, 1'($urandom % 2), lat);
      wait_idle(cnt);
      if (n <= 4'd4)      check("rand_access_busy", 64'(cnt), 64'(4 + lat));
      else if (n == 4'd8) check("rand_clear_busy", 64'(cnt), 64'(SETS));
      else if (n == 4'd9) check("rand_print_busy", 64'(cnt), 64'(2 * SETS + stall_total));
      else                check("rand_bad_busy", 64'(cnt), 64'(0));
      check_counters();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset during WAIT_MESI aborts the access without write-back
    issue(4'd0, 32'h0000_2080, 1'b1, 6);
    @(negedge clk);
    @(negedge clk);
    check("in_wait_mesi", 64'(bus.lk_valid), 64'(1));
    #2 rst = 1'b1;
    exp_q.delete();
    resp_q.delete();
    m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
    #1 check("abort_outputs_zero", 64'(any_output()), 64'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_abort", 64'(bus.cmd_ready), 64'(1));
    repeat (10) @(negedge clk);
    check_counters();

    // unsupported code
    issue(4'd5, 32'h0000_0040, 1'b0, 0);
    check("bad_cmd_ready_held", 64'(bus.cmd_ready), 64'(1));
    wait_idle(cnt);
    check("bad_cmd_busy_cycles", 64'(cnt), 64'(0));
    @(negedge clk);
    check("err_cmd_single_pulse", 64'(bus.err_cmd), 64'(0));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
